// File: rtl/ppm_frame_ctrl.sv
// Frame controller for the PPM receive path: tracks SOF/EOF framing, forwards
// in-frame bytes with a registered strobe, and reports overflow/timeout/restart/stray-EOF.
module ppm_frame_ctrl #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7,
  parameter int TIMEOUT = 1024,
  parameter int TMO_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sof_in,
  input  logic              eof_in,
  input  logic              byte_vld_in,
  input  logic [DATA_W-1:0] byte_in,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              frame_active,
  output logic              frame_done,
  output logic [LEN_W-1:0]  frame_len,
  output logic              frame_err,
  output logic [1:0]        err_code
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] CNT_ONE   = LEN_W'(1'b1);
  localparam logic [TMO_W-1:0] TMO_C     = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1'b1);
  localparam logic [1:0] ERR_OVF = 2'b00;
  localparam logic [1:0] ERR_TMO = 2'b01;
  localparam logic [1:0] ERR_RST = 2'b10;
  localparam logic [1:0] ERR_EOF = 2'b11;

  state_t              state_r, state_s;
  logic [LEN_W-1:0]    cnt_r, cnt_s;
  logic [TMO_W-1:0]    tmr_r, tmr_s, tmr_inc_s;
  logic [DATA_W-1:0]   dout_r, dout_s;
  logic                dout_vld_r, dout_vld_s;
  logic                active_r;
  logic                done_r, done_s;
  logic [LEN_W-1:0]    len_r, len_s;
  logic                err_r, err_s;
  logic [1:0]          code_r, code_s;

  assign tmr_inc_s = tmr_r + TMO_ONE;

  // Next-state and next-output decode; ACTIVE branches follow the event priority.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    tmr_s      = tmr_r;
    dout_s     = dout_r;
    dout_vld_s = 1'b0;
    done_s     = 1'b0;
    len_s      = len_r;
    err_s      = 1'b0;
    code_s     = code_r;
    case (state_r)
      IDLE: begin
        if (sof_in) begin
          state_s = ACTIVE;
          cnt_s   = '0;
          tmr_s   = '0;
          dout_s  = '0;
        end else if (eof_in) begin
          err_s  = 1'b1;
          code_s = ERR_EOF;
        end else begin
          state_s = IDLE;
        end
      end
      ACTIVE: begin
        if (byte_vld_in && (cnt_r == MAX_LEN_C)) begin
          err_s   = 1'b1;
          code_s  = ERR_OVF;
          state_s = IDLE;
        end else if (eof_in) begin
          done_s  = 1'b1;
          state_s = IDLE;
          if (byte_vld_in) begin
            dout_s     = byte_in;
            dout_vld_s = 1'b1;
            len_s      = cnt_r + CNT_ONE;
          end else begin
            len_s = cnt_r;
          end
        end else if (sof_in) begin
          err_s  = 1'b1;
          code_s = ERR_RST;
          cnt_s  = '0;
          tmr_s  = '0;
        end else if (byte_vld_in) begin
          dout_s     = byte_in;
          dout_vld_s = 1'b1;
          cnt_s      = cnt_r + CNT_ONE;
          tmr_s      = '0;
        end else if (TIMEOUT == 32'sd0) begin
          tmr_s = tmr_r;
        end else if (tmr_inc_s == TMO_C) begin
          err_s   = 1'b1;
          code_s  = ERR_TMO;
          state_s = IDLE;
        end else begin
          tmr_s = tmr_inc_s;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= '0;
      tmr_r      <= '0;
      dout_r     <= '0;
      dout_vld_r <= 1'b0;
      active_r   <= 1'b0;
      done_r     <= 1'b0;
      len_r      <= '0;
      err_r      <= 1'b0;
      code_r     <= 2'b00;
    end else begin
      cnt_r      <= cnt_s;
      tmr_r      <= tmr_s;
      dout_r     <= dout_s;
      dout_vld_r <= dout_vld_s;
      active_r   <= (state_s == ACTIVE);
      done_r     <= done_s;
      len_r      <= len_s;
      err_r      <= err_s;
      code_r     <= code_s;
    end
  end

  assign dout         = dout_r;
  assign dout_vld     = dout_vld_r;
  assign frame_active = active_r;
  assign frame_done   = done_r;
  assign frame_len    = len_r;
  assign frame_err    = err_r;
  assign err_code     = code_r;

endmodule

// File: tb/tb_ppm_frame_ctrl.sv
// Directed self-checking bench for ppm_frame_ctrl (MAX_LEN=4, TIMEOUT=8).
module tb_ppm_frame_ctrl;
  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 4;
  localparam int LEN_W   = 7;
  localparam int TIMEOUT = 8;
  localparam int TMO_W   = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sof_in, eof_in, byte_vld_in;
  logic [DATA_W-1:0] byte_in;
  logic [DATA_W-1:0] dout;
  logic              dout_vld, frame_active, frame_done, frame_err;
  logic [LEN_W-1:0]  frame_len;
  logic [1:0]        err_code;

  int errors = 0;
  int checks = 0;

  ppm_frame_ctrl #(
    .DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W),
    .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sof_in(sof_in), .eof_in(eof_in),
    .byte_vld_in(byte_vld_in), .byte_in(byte_in), .dout(dout),
    .dout_vld(dout_vld), .frame_active(frame_active), .frame_done(frame_done),
    .frame_len(frame_len), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic cycle(input logic s, input logic e, input logic v, input logic [7:0] b);
    sof_in = s; eof_in = e; byte_vld_in = v; byte_in = b;
    @(posedge clk); #1;
    sof_in = 1'b0; eof_in = 1'b0; byte_vld_in = 1'b0; byte_in = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sof_in = 1'b0; eof_in = 1'b0; byte_vld_in = 1'b0; byte_in = 8'h00;
    #3;
    checks++;
    if ({dout, dout_vld, frame_active, frame_done, frame_len, frame_err, err_code} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got dout=%h vld=%b act=%b done=%b len=%0d err=%b code=%b exp all zero",
               dout, dout_vld, frame_active, frame_done, frame_len, frame_err, err_code);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, 8'hEE);
    checks++;
    if (dout_vld !== 1'b0 || dout !== 8'h00 || frame_active !== 1'b0) begin
      errors++;
      $display("FAIL idle_byte_ignored got vld=%b dout=%h act=%b exp 0 00 0", dout_vld, dout, frame_active);
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] bytes [3] = '{8'hA1, 8'hB2, 8'hC3};
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if (frame_active !== 1'b1 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_sof got act=%b err=%b exp 1 0", frame_active, frame_err);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, bytes[i]);
      checks++;
      if (dout_vld !== 1'b1 || dout !== bytes[i]) begin
        errors++;
        $display("FAIL basic_byte%0d got vld=%b dout=%h exp 1 %h", i, dout_vld, dout, bytes[i]);
      end
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (dout_vld !== 1'b0 || dout !== bytes[i]) begin
        errors++;
        $display("FAIL basic_hold%0d got vld=%b dout=%h exp 0 %h", i, dout_vld, dout, bytes[i]);
      end
    end
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (frame_done !== 1'b1 || frame_len !== 7'd3 || frame_err !== 1'b0 || frame_active !== 1'b0) begin
      errors++;
      $display("FAIL basic_close got done=%b len=%0d err=%b act=%b exp 1 3 0 0",
               frame_done, frame_len, frame_err, frame_active);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (frame_done !== 1'b0 || frame_len !== 7'd3) begin
      errors++;
      $display("FAIL basic_done_pulse got done=%b len=%0d exp 0 3", frame_done, frame_len);
    end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'(8'h10 + i));
      checks++;
      if (dout_vld !== 1'b1 || dout !== 8'(8'h10 + i) || frame_err !== 1'b0) begin
        errors++;
        $display("FAIL ovf_byte%0d got vld=%b dout=%h err=%b exp 1 %h 0", i, dout_vld, dout, frame_err, 8'(8'h10 + i));
      end
    end
    cycle(1'b0, 1'b0, 1'b1, 8'h99);
    checks++;
    if (dout_vld !== 1'b0 || dout !== 8'h13 || frame_err !== 1'b1 || err_code !== 2'b00 ||
        frame_active !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drop got vld=%b dout=%h err=%b code=%b act=%b done=%b exp 0 13 1 00 0 0",
               dout_vld, dout, frame_err, err_code, frame_active, frame_done);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (frame_err !== 1'b0 || err_code !== 2'b00 || frame_active !== 1'b0) begin
      errors++;
      $display("FAIL ovf_after got err=%b code=%b act=%b exp 0 00 0", frame_err, err_code, frame_active);
    end
  endtask

  task automatic test_timeout();
    logic early;
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h5A);
    early = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      if (frame_err !== 1'b0 || frame_active !== 1'b1) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL tmo_early got early_abort=%b exp 0", early);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (frame_err !== 1'b1 || err_code !== 2'b01 || frame_active !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL tmo_abort got err=%b code=%b act=%b done=%b exp 1 01 0 0",
               frame_err, err_code, frame_active, frame_done);
    end
  endtask

  task automatic test_restart();
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if (dout !== 8'h00 || frame_active !== 1'b1) begin
      errors++;
      $display("FAIL rst_sof_clear got dout=%h act=%b exp 00 1", dout, frame_active);
    end
    cycle(1'b0, 1'b0, 1'b1, 8'h11);
    cycle(1'b0, 1'b0, 1'b1, 8'h22);
    cycle(1'b1, 1'b0, 1'b1, 8'h66);
    checks++;
    if (frame_err !== 1'b1 || err_code !== 2'b10 || frame_active !== 1'b1 || dout_vld !== 1'b0 || dout !== 8'h22) begin
      errors++;
      $display("FAIL restart_err got err=%b code=%b act=%b vld=%b dout=%h exp 1 10 1 0 22",
               frame_err, err_code, frame_active, dout_vld, dout);
    end
    cycle(1'b0, 1'b0, 1'b1, 8'h33);
    checks++;
    if (dout_vld !== 1'b1 || dout !== 8'h33 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL restart_byte got vld=%b dout=%h err=%b exp 1 33 0", dout_vld, dout, frame_err);
    end
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (frame_done !== 1'b1 || frame_len !== 7'd1 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL restart_close got done=%b len=%0d err=%b exp 1 1 0", frame_done, frame_len, frame_err);
    end
  endtask

  task automatic test_stray_and_same_cycle();
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (frame_err !== 1'b1 || err_code !== 2'b11 || frame_active !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL stray_eof got err=%b code=%b act=%b done=%b exp 1 11 0 0",
               frame_err, err_code, frame_active, frame_done);
    end
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    checks++;
    if (frame_err !== 1'b0 || frame_active !== 1'b1 || frame_done !== 1'b0 || err_code !== 2'b11) begin
      errors++;
      $display("FAIL sof_eof_idle got err=%b act=%b done=%b code=%b exp 0 1 0 11",
               frame_err, frame_active, frame_done, err_code);
    end
    cycle(1'b0, 1'b0, 1'b1, 8'h44);
    cycle(1'b0, 1'b1, 1'b1, 8'h55);
    checks++;
    if (dout_vld !== 1'b1 || dout !== 8'h55 || frame_done !== 1'b1 || frame_len !== 7'd2 || frame_active !== 1'b0) begin
      errors++;
      $display("FAIL byte_with_eof got vld=%b dout=%h done=%b len=%0d act=%b exp 1 55 1 2 0",
               dout_vld, dout, frame_done, frame_len, frame_active);
    end
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (frame_done !== 1'b1 || frame_len !== 7'd0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL empty_frame got done=%b len=%0d err=%b exp 1 0 0", frame_done, frame_len, frame_err);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h81);
    cycle(1'b0, 1'b1, 1'b1, 8'h82);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h83);
    cycle(1'b0, 1'b0, 1'b1, 8'h84);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dout, dout_vld, frame_active, frame_done, frame_len, frame_err, err_code} !== 22'd0) begin
      errors++;
      $display("FAIL async_reset got dout=%h vld=%b act=%b done=%b len=%0d err=%b code=%b exp all zero",
               dout, dout_vld, frame_active, frame_done, frame_len, frame_err, err_code);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (frame_done !== 1'b0 || frame_err !== 1'b0 || frame_active !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got done=%b err=%b act=%b exp 0 0 0", frame_done, frame_err, frame_active);
    end
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h77);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (frame_done !== 1'b1 || frame_len !== 7'd1 || dout !== 8'h77) begin
      errors++;
      $display("FAIL post_reset_frame got done=%b len=%0d dout=%h exp 1 1 77", frame_done, frame_len, dout);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overflow();
    test_timeout();
    test_restart();
    test_stray_and_same_cycle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
